// File: rtl/nn_xor_driver.sv
// Stimulus/check sequencer for an NN XOR-evaluation core: applies the four XOR
// input pairs as FP operands, thresholds each settled result and reports pass/fail.
module nn_xor_driver #(
    parameter int exp_width     = 8,
    parameter int mant_width    = 24,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rst_l,
    input  logic                            start,
    input  logic [2:0]                      round_mode_cfg,
    output logic [exp_width+mant_width-1:0] A,
    output logic [exp_width+mant_width-1:0] B,
    output logic [2:0]                      round_mode,
    input  logic [exp_width+mant_width-1:0] XOR_output,
    input  logic [4:0]                      exceptions,
    output logic                            busy,
    output logic                            result_valid,
    output logic [1:0]                      result_idx,
    output logic                            result_bit,
    output logic                            result_ok,
    output logic                            done,
    output logic                            pass,
    output logic [4:0]                      exc_sticky,
    output logic                            nan_seen
);

    localparam int DW = exp_width + mant_width;
    localparam int FW = mant_width - 1;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] FP_ONE  = {1'b0, 1'b0, {(exp_width-1){1'b1}}, {FW{1'b0}}};
    localparam logic [DW-1:0] FP_HALF = {2'b00, {(exp_width-2){1'b1}}, 1'b0, {FW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [2:0]      r_round;
    logic            r_busy;
    logic            r_valid;
    logic [1:0]      r_res_idx;
    logic            r_res_bit;
    logic            r_res_ok;
    logic            r_done;
    logic            r_pass;
    logic            r_acc;
    logic [4:0]      r_exc;
    logic            r_nan;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_idx;

    logic [exp_width-1:0] w_exp;
    logic [FW-1:0]        w_frac;
    logic                 w_is_nan;
    logic                 w_bit;
    logic                 w_ok;
    logic                 w_start_run;
    logic                 w_cnt_last;
    logic                 w_last_vec;
    logic [1:0]           w_idx_nxt;

    assign w_exp       = XOR_output[DW-2 -: exp_width];
    assign w_frac      = XOR_output[FW-1:0];
    assign w_is_nan    = (&w_exp) && (|w_frac);
    // Sign-magnitude compare: for non-negative, non-NaN values the magnitude bits order like the value.
    assign w_bit       = !XOR_output[DW-1] && !w_is_nan && (XOR_output[DW-2:0] >= FP_HALF[DW-2:0]);
    assign w_ok        = (w_bit == (r_idx[1] ^ r_idx[0])) && !w_is_nan;
    assign w_start_run = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_cnt_last  = (r_cnt == CNT_LAST);
    assign w_last_vec  = (r_idx == 2'd3);
    assign w_idx_nxt   = r_idx + 2'd1;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_cnt_last) w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_state_nxt = w_last_vec ? ST_DONE : ST_SETTLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_a       <= '0;
            r_b       <= '0;
            r_round   <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_res_idx <= '0;
            r_res_bit <= 1'b0;
            r_res_ok  <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_acc     <= 1'b0;
            r_exc     <= '0;
            r_nan     <= 1'b0;
            r_cnt     <= '0;
            r_idx     <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_start_run) begin
                r_a     <= '0;
                r_b     <= '0;
                r_round <= round_mode_cfg;
                r_exc   <= '0;
                r_nan   <= 1'b0;
                r_done  <= 1'b0;
                r_pass  <= 1'b0;
                r_acc   <= 1'b1;
                r_busy  <= 1'b1;
                r_cnt   <= '0;
                r_idx   <= '0;
            end else begin
                case (r_state)
                    ST_SETTLE: begin
                        r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
                    end
                    ST_CAPTURE: begin
                        r_valid   <= 1'b1;
                        r_res_idx <= r_idx;
                        r_res_bit <= w_bit;
                        r_res_ok  <= w_ok;
                        r_exc     <= r_exc | exceptions;
                        r_nan     <= r_nan | w_is_nan;
                        r_acc     <= r_acc & w_ok;
                        if (w_last_vec) begin
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                            r_pass <= r_acc & w_ok;
                        end else begin
                            r_idx <= w_idx_nxt;
                            r_a   <= w_idx_nxt[1] ? FP_ONE : '0;
                            r_b   <= w_idx_nxt[0] ? FP_ONE : '0;
                            r_cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign A            = r_a;
    assign B            = r_b;
    assign round_mode   = r_round;
    assign busy         = r_busy;
    assign result_valid = r_valid;
    assign result_idx   = r_res_idx;
    assign result_bit   = r_res_bit;
    assign result_ok    = r_res_ok;
    assign done         = r_done;
    assign pass         = r_pass;
    assign exc_sticky   = r_exc;
    assign nan_seen     = r_nan;

endmodule

// File: doc/nn_xor_driver.md
Name: nn_xor_driver

Overview:
Sequencer that drives an NN XOR-evaluation core and checks its result. It is the stimulus and check side of the NN interface: it applies the four XOR input pairs as floating-point operands and waits a fixed settle time for each. It then samples the core output, thresholds it to a bit and reports per-vector results plus an overall pass/fail. Weights and biases are loaded elsewhere; this block owns only A, B, round_mode and the result capture.

Parameters:
exp_width, 8, exponent field width
mant_width, 24, mantissa width including hidden bit; stored fraction is mant_width-1 bits
SETTLE_CYCLES, 64, cycles each vector is held before capture (minimum 1)

Ports:
clk  in  1  clock
rst_l  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run when idle
round_mode_cfg  in  3  rounding mode, latched at start
A  out  exp_width+mant_width  FP operand A to core
B  out  exp_width+mant_width  FP operand B to core
round_mode  out  3  rounding mode to core
XOR_output  in  exp_width+mant_width  FP result from core
exceptions  in  5  core exception flags
busy  out  1  run in progress
result_valid  out  1  one-cycle strobe, per-vector result
result_idx  out  2  vector index of current result
result_bit  out  1  thresholded core output
result_ok  out  1  result_bit equals expected XOR and value not NaN
done  out  1  run complete; held until next start
pass  out  1  valid when done; all four vectors ok
exc_sticky  out  5  OR of exceptions sampled at all captures this run
nan_seen  out  1  any captured output was NaN

Behaviour:
- Reset (async, rst_l=0): state IDLE; every output 0; round_mode=0; counters cleared. Takes effect mid-run. No result_valid is emitted after reset. A/B return to 0.0.
- FP constants: 0.0 = all zeros. 1.0 = {0, 2^(exp_width-1)-1, zeros}. 0.5 threshold HALF = {0, 2^(exp_width-1)-2, zeros}. With defaults: 0x3F800000 and 0x3F000000.
- Vector order by idx: 0:(0,0) 1:(0,1) 2:(1,0) 3:(1,1). Expected bit = a XOR b.
- FSM states: IDLE, SETTLE, CAPTURE, DONE.
- IDLE or DONE, start=1 at an edge:
  - A/B load vector 0; round_mode loads round_mode_cfg.
  - Clear exc_sticky, nan_seen, done and the pass accumulator.
  - busy=1; counter=0; go to SETTLE.
- SETTLE: counter increments each edge. At the edge where counter==SETTLE_CYCLES-1, go to CAPTURE. A/B are stable for exactly SETTLE_CYCLES cycles before CAPTURE.
- CAPTURE (1 cycle), at its ending edge:
  - Sample XOR_output and exceptions.
  - Set result_bit, result_ok and result_idx; assert result_valid for the following cycle only.
  - OR exceptions into exc_sticky.
  - If idx<3: advance idx, load the next A/B, counter=0, go to SETTLE.
  - If idx==3: go to DONE with busy=0, done=1, pass = AND of all four result_ok.
- Per vector: SETTLE_CYCLES+1 cycles. First result_valid occurs SETTLE_CYCLES+1 cycles after the start edge.
- Threshold: result_bit=1 iff sign=0, value is not NaN, and magnitude bits ≥ HALF magnitude (unsigned compare of bits [data_width-2:0]). Exactly 0.5 gives 1. Negative values, ±0, denormals and −inf give 0. +inf gives 1.
- NaN (exponent all ones, fraction ≠0): result_bit=0, result_ok=0, nan_seen=1.
- start while busy is ignored: no restart and no effect on outputs.
- DONE holds A/B at vector 3 and keeps done/pass/exc_sticky stable until start or reset.
- round_mode is constant for the whole run; changes to round_mode_cfg mid-run are ignored.

Test Plan:
- Ideal stub core (after settle returns 0x00000000, 0x3F800000, 0x3F800000, 0x00000000), SETTLE_CYCLES=4, start pulse → result_valid at cycles 5, 10, 15, 20 after start with idx 0..3; result_bit 0,1,1,0; done=1 and pass=1 after the 4th capture; A/B sequence 0/0, 0/3F800000, 3F800000/0, 3F800000/3F800000.
- Stub returns 0x3E800000 (0.25) for idx1 → result_bit=0 and result_ok=0 at idx1; pass=0. Stub returns 0x3F000000 exactly for idx2 → result_bit=1, ok=1. Stub returns 0xBF800000 for idx0 → result_bit=0, ok=1.
- Stub returns 0x7FC00000 at idx3 → result_ok=0, nan_seen=1, pass=0.
- Stub raises exceptions 5'b00001 at idx0 and 5'b10000 at idx2 → exc_sticky=5'b10001 at done. A second start → exc_sticky cleared to 0 on the start edge.
- Assert start repeatedly during SETTLE of idx1 → sequence and timing unchanged. round_mode_cfg=3'b010 at start, then changed to 3'b001 → round_mode stays 3'b010.
- Drop rst_l mid-SETTLE of idx2 → all outputs 0 immediately and no result_valid. After release, start yields a full correct run from idx0.
